// File: rtl/rca_pkg.sv
// rca_pkg: shared definitions for the operand sequencer around the clocked
// 4-bit adder.
//   - default parameter values (FIFO depth, start-hold length, sample edge)
//   - FSM state encoding
//   - operand pair layout as stored in the FIFO ({a, b})
package rca_pkg;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_START_HOLD = 2;
  localparam int DEF_WAIT_CYC   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } op_pair_t;

endpackage

// File: rtl/rca_op_fifo.sv
// rca_op_fifo: operand FIFO, 8-bit entries, DEPTH entries (power of two).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write request (ignored while full)
//   i_wdata      entry to write
//   o_full       no free entry
//   i_pop        read request (ignored while empty)
//   o_rdata      head entry, valid whenever o_empty is low
//   o_empty      no occupied entry
//   o_level      occupied entries (registered)
module rca_op_fifo
  import rca_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [7:0]                 i_wdata,
  output logic                       o_full,
  input  logic                       i_pop,
  output logic [7:0]                 o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_wr_en;
  logic          w_rd_en;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_wr_en = i_push & ~o_full;
  assign w_rd_en = i_pop & ~o_empty;

  // Head is read combinationally so the sequencer can load the adder
  // operands on the same edge it pops.
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rca_op_seq.sv
// rca_op_seq: queues operand pairs and sequences them one at a time through
// an external clocked 4-bit adder, returning {carry, sum} with valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready = FIFO not full)
//   in_a, in_b            operands
//   add_start             start level to the adder
//   add_a, add_b          registered operands to the adder
//   add_s, add_cout       adder registered sum / carry
//   out_valid/out_ready   result handshake
//   out_sum               {carry, sum}
//   busy                  FSM not idle
//   fifo_level            occupied FIFO entries
//
// Timing: the pop edge loads add_a/add_b and raises add_start. Counting the
// pop edge as edge 0, add_start is high across edges 1..START_HOLD and the
// result is captured on edge WAIT_CYC (the WAIT_CYC-th edge with edge 1 being
// the first one that sees add_start high). With out_ready held high, OUT lasts
// one cycle and IDLE one cycle, giving a period of WAIT_CYC+2.
module rca_op_seq
  import rca_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int START_HOLD = DEF_START_HOLD,
  parameter int WAIT_CYC   = DEF_WAIT_CYC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_a,
  input  logic [3:0]                    in_b,
  output logic                          add_start,
  output logic [3:0]                    add_a,
  output logic [3:0]                    add_b,
  input  logic [3:0]                    add_s,
  input  logic                          add_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4:0]                    out_sum,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(WAIT_CYC + 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_add_start;
  logic          w_add_start_next;
  logic [3:0]    r_add_a;
  logic [3:0]    r_add_b;
  logic          r_out_valid;
  logic [4:0]    r_out_sum;
  logic          w_pop;
  logic          w_load_res;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_fifo_rdata;
  op_pair_t      w_head;

  rca_op_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_wdata ({in_a, in_b}),
    .o_full  (w_fifo_full),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  assign w_head = op_pair_t'(w_fifo_rdata);

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_add_start_next = r_add_start;
    w_pop            = 1'b0;
    w_load_res       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop            = 1'b1;
          w_cnt_next       = '0;
          w_add_start_next = 1'b1;
          w_state_next     = ST_START;
        end
      end
      ST_START: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CW'(START_HOLD - 1)) begin
          w_add_start_next = 1'b0;
          w_state_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CW'(WAIT_CYC - 1)) begin
          w_load_res   = 1'b1;
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_add_start_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_add_start <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_add_start <= w_add_start_next;
      // Operands only change on a pop, so they stay put through OUT.
      if (w_pop) begin
        r_add_a <= w_head.a;
        r_add_b <= w_head.b;
      end
      if (w_load_res) begin
        r_out_sum   <= {add_cout, add_s};
        r_out_valid <= 1'b1;
      end else if (r_state == ST_OUT && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = ~w_fifo_full;
  assign add_start = r_add_start;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rca_op_seq.sv
// tb_rca_op_seq: randomized and directed stimulus for rca_op_seq with a
// clocked 4-bit adder model on the add_* ports. Expected sums are a+b
// computed at push time and queued; a monitor pops and compares on each
// result handshake.
module tb_rca_op_seq;
  import rca_pkg::*;

  localparam int FD = DEF_FIFO_DEPTH;
  localparam int SH = DEF_START_HOLD;
  localparam int WC = DEF_WAIT_CYC;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_a = '0;
  logic [3:0]    in_b = '0;
  logic          in_ready;
  logic          add_start;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic [3:0]    add_s = '0;
  logic          add_cout = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_sum;
  logic          busy;
  logic [LW-1:0] fifo_level;

  int ready_mode = 1;  // 0 low, 1 high, 2 random
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Clocked 4-bit adder: registers the sum while start is high.
  always @(posedge clk) begin
    if (add_start) {add_cout, add_s} <= 5'(add_a) + 5'(add_b);
  end

  always @(posedge clk) cyc <= cyc + 1;

  rca_op_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_s      (add_s),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // out_ready driver, updated 2 time units after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  logic [4:0] sb[$];
  int         pop_cyc[$];
  int         last_pop = 0;
  int         outs_seen = 0;
  int         hi_run = 0;
  int         lo_run = 0;
  bit         started = 0;
  logic       p_busy = 0;
  logic       p_ov = 0;
  logic       p_as = 0;
  logic [7:0] p_ops = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      p_busy = 0; p_ov = 0; p_as = 0;
      hi_run = 0; lo_run = 0; started = 0;
    end else begin
      if (in_valid && in_ready) sb.push_back(5'(in_a) + 5'(in_b));
      if (out_valid && out_ready) begin
        outs_seen++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got out_sum=%0d, required no result", out_sum);
        end else begin
          chk("out_sum", int'(out_sum), int'(sb.pop_front()));
        end
      end
      if (busy && !p_busy) begin
        pop_cyc.push_back(cyc);
        last_pop = cyc;
      end
      if (out_valid && !p_ov) chk("pop_to_valid_edges", cyc - last_pop, WC);
      if (busy && p_busy) chk("operand_hold", int'({add_a, add_b}), int'(p_ops));
      if (add_start) begin
        if (!p_as && started) chk("start_low_gap_ge3", int'(lo_run >= 3), 1);
        hi_run = p_as ? hi_run + 1 : 1;
        started = 1;
      end else begin
        if (p_as) chk("start_width", hi_run, SH);
        lo_run = p_as ? 1 : lo_run + 1;
      end
      p_busy = busy; p_ov = out_valid; p_as = add_start; p_ops = {add_a, add_b};
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called 2 units after a rising edge; returns at the same phase.
  task automatic push_op(input logic [3:0] a, input logic [3:0] b);
    bit ok = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    if (!ok) chk("push_accept_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && fifo_level == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_add_start"}, int'(add_start), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_add_a"}, int'(add_a), 0);
    chk({tag, "_add_b"}, int'(add_b), 0);
    chk({tag, "_out_sum"}, int'(out_sum), 0);
    chk({tag, "_fifo_level"}, int'(fifo_level), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int n;
    int base;
    bit got;
    logic [4:0] held;

    // Reset state and quiet period after release.
    step(3);
    @(negedge clk);
    chk_zero_outputs("reset");
    step(1);
    rst_n = 1'b1;
    step(5);
    @(negedge clk);
    chk_zero_outputs("post_release");
    step(1);

    // 3 + 4 with latency check in the monitor.
    push_op(4'd3, 4'd4);
    wait_drain(100);

    // Back-to-back 15+1, 15+15 at full throughput.
    push_op(4'd15, 4'd1);
    push_op(4'd15, 4'd15);
    wait_drain(100);
    n = pop_cyc.size();
    if (n >= 2) chk("throughput_period", pop_cyc[n-1] - pop_cyc[n-2], WC + 2);
    else chk("throughput_pops_seen", n, 2);

    // Fill with downstream stalled; sixth push must be refused.
    ready_mode = 0;
    step(2);
    for (int i = 0; i < 5; i++) push_op(4'($urandom), 4'($urandom));
    in_a = 4'($urandom); in_b = 4'($urandom); in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_level", int'(fifo_level), FD);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;

    // Stall in OUT: result stable, no new start.
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    chk("stall_reached_out", int'(got), 1);
    held = out_sum;
    repeat (20) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_out_sum", int'(out_sum), int'(held));
      chk("stall_no_start", int'(add_start), 0);
    end
    step(1);
    ready_mode = 1;
    wait_drain(300);

    // Random traffic with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      push_op(4'($urandom), 4'($urandom));
      step($urandom_range(0, 3));
    end
    wait_drain(2000);
    ready_mode = 1;
    step(2);

    // Reset during WAIT with two entries queued.
    for (int i = 0; i < 3; i++) push_op(4'($urandom), 4'($urandom));
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (fifo_level == 2 && busy && !add_start && !out_valid) got = 1;
    end
    chk("reached_wait_with_2_queued", int'(got), 1);
    @(posedge clk);
    #2;
    base = outs_seen;
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midop_reset");
    step(2);
    rst_n = 1'b1;
    step(3 * (WC + 2));
    @(negedge clk);
    chk("no_result_after_reset", outs_seen - base, 0);
    chk("idle_after_reset_busy", int'(busy), 0);
    chk("idle_after_reset_level", int'(fifo_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
